// File: rtl/instr_mem_loadable_if.sv
// Fetch and program-load signals of the loadable instruction memory.
// Load handshake: a word transfers on a rising clk edge where ld_valid && ld_ready.
// ld_data is held stable while ld_valid is high and the word has not been taken.
interface instr_mem_loadable_if #(
   parameter int OPCODE_W  = 8,
   parameter int OPERAND_W = 18,
   parameter int ADDR_W    = 8
);
   localparam int IW = OPCODE_W + OPERAND_W;

   logic                 rd_en;
   logic [ADDR_W-1:0]    rd_addr;
   logic [IW-1:0]        instr_out;
   logic [OPCODE_W-1:0]  opcode_out;
   logic [OPERAND_W-1:0] operand_out;
   logic                 instr_valid;
   logic                 addr_err;

   logic                 ld_start;
   logic [ADDR_W-1:0]    ld_base;
   logic [ADDR_W:0]      ld_len;
   logic                 ld_valid;
   logic [IW-1:0]        ld_data;
   logic                 ld_ready;
   logic                 ld_busy;
   logic                 ld_done;
   logic                 ld_err;
   logic [IW-1:0]        ld_csum;

   modport slave (
      input  rd_en, rd_addr, ld_start, ld_base, ld_len, ld_valid, ld_data,
      output instr_out, opcode_out, operand_out, instr_valid, addr_err,
             ld_ready, ld_busy, ld_done, ld_err, ld_csum
   );

   modport master (
      output rd_en, rd_addr, ld_start, ld_base, ld_len, ld_valid, ld_data,
      input  instr_out, opcode_out, operand_out, instr_valid, addr_err,
             ld_ready, ld_busy, ld_done, ld_err, ld_csum
   );
endinterface

// File: rtl/instr_mem_loadable.sv
// Synchronous instruction memory with a registered fetch port and a streaming
// program loader (IDLE/LOAD/DONE FSM, bounds check, XOR checksum).
module instr_mem_loadable #(
   parameter int OPCODE_W   = 8,
   parameter int OPERAND_W  = 18,
   parameter int ADDR_W     = 8,
   parameter int DEPTH      = 201,
   parameter int NOP_OPCODE = 46
) (
   input  logic                 clk,
   input  logic                 reset,
   instr_mem_loadable_if.slave  bus,
   output logic [1:0]           fsm_state
);
   localparam int IW = OPCODE_W + OPERAND_W;
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
   localparam logic [IW-1:0] NOP_WORD = {OPCODE_W'(NOP_OPCODE), OPERAND_W'(0)};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [IW-1:0]     mem [DEPTH];
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   cnt;
   logic              accept;
   logic              fetch;
   logic              ptr_in_range;
   logic              rd_in_range;
   logic              start;

   assign ptr_in_range = ({1'b0, ptr} < DEPTH_W);
   assign rd_in_range  = ({1'b0, bus.rd_addr} < DEPTH_W);
   assign accept       = bus.ld_valid && bus.ld_ready;
   assign start        = (state == IDLE) && bus.ld_start;
   // The fetch port is blocked only while words are streaming in.
   assign fetch        = bus.rd_en && (state != LOAD);
   assign fsm_state    = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      bus.ld_ready = 1'b0;
      bus.ld_busy  = 1'b0;
      bus.ld_done  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ld_start) begin
               state_nx = (bus.ld_len == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            bus.ld_ready = 1'b1;
            bus.ld_busy  = 1'b1;
            if (bus.ld_valid && (cnt == (ADDR_W+1)'(1))) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            bus.ld_done = 1'b1;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr         <= '0;
         cnt         <= '0;
         bus.ld_csum <= '0;
         bus.ld_err  <= 1'b0;
      end else if (start) begin
         ptr         <= bus.ld_base;
         cnt         <= bus.ld_len;
         bus.ld_csum <= '0;
         bus.ld_err  <= 1'b0;
      end else if (accept) begin
         ptr         <= ptr + 1'b1;
         cnt         <= cnt - 1'b1;
         bus.ld_csum <= bus.ld_csum ^ bus.ld_data;
         if (!ptr_in_range) begin
            bus.ld_err <= 1'b1;
         end
      end
   end

   // Memory array has no reset so that a reset mid-load keeps written words.
   always_ff @(posedge clk) begin
      if (accept && ptr_in_range) begin
         mem[ptr] <= bus.ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.instr_out   <= '0;
         bus.instr_valid <= 1'b0;
         bus.addr_err    <= 1'b0;
      end else begin
         bus.instr_valid <= fetch;
         if (fetch) begin
            if (rd_in_range) begin
               bus.instr_out <= mem[bus.rd_addr];
               bus.addr_err  <= 1'b0;
            end else begin
               bus.instr_out <= NOP_WORD;
               bus.addr_err  <= 1'b1;
            end
         end
      end
   end

   assign bus.opcode_out  = bus.instr_out[IW-1 -: OPCODE_W];
   assign bus.operand_out = bus.instr_out[OPERAND_W-1:0];
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Testbench for instr_mem_loadable: fetch vector table, load sequences and a
// fetch scoreboard fed by a shadow memory model.
module tb_instr_mem_loadable;
   localparam int OPCODE_W   = 8;
   localparam int OPERAND_W  = 18;
   localparam int ADDR_W     = 8;
   localparam int DEPTH      = 201;
   localparam int NOP_OPCODE = 46;
   localparam int IW         = OPCODE_W + OPERAND_W;
   localparam logic [IW-1:0] NOP_WORD = {OPCODE_W'(NOP_OPCODE), OPERAND_W'(0)};

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic              exp_err;
      logic [IW-1:0]     exp_word;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] fsm_state;

   int checks = 0;
   int errors = 0;

   logic [IW:0]   exp_q[$];
   logic [IW-1:0] model_mem [DEPTH];
   logic [IW-1:0] m_csum;
   logic          m_err;
   logic [IW-1:0] ld_words[$];
   logic [IW:0]   mon_e;
   vec_t          vecs [8];

   instr_mem_loadable_if #(.OPCODE_W(OPCODE_W), .OPERAND_W(OPERAND_W), .ADDR_W(ADDR_W)) bus ();

   instr_mem_loadable #(
      .OPCODE_W(OPCODE_W), .OPERAND_W(OPERAND_W), .ADDR_W(ADDR_W),
      .DEPTH(DEPTH), .NOP_OPCODE(NOP_OPCODE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] pat(input int a);
      return {OPCODE_W'(a ^ 'h5A), OPERAND_W'(a * 37 + 5)};
   endfunction

   function automatic logic [IW:0] model_exp(input int a);
      if (a < DEPTH) return {1'b0, model_mem[a]};
      return {1'b1, NOP_WORD};
   endfunction

   // scoreboard: every fetch result is popped and compared when instr_valid shows
   always @(negedge clk) begin
      if (bus.instr_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got instr_valid=1 expected 0 (instr_out=%0h)", bus.instr_out);
         end else begin
            mon_e = exp_q.pop_front();
            check("fetch_word", 64'(bus.instr_out), 64'(mon_e[IW-1:0]));
            check("fetch_err", 64'(bus.addr_err), 64'(mon_e[IW]));
            check("fetch_opcode", 64'(bus.opcode_out), 64'(mon_e[IW-1 -: OPCODE_W]));
            check("fetch_operand", 64'(bus.operand_out), 64'(mon_e[OPERAND_W-1:0]));
         end
      end
   end

   // driver tasks
   task automatic fetch(input int a, input logic [IW:0] e);
      bus.rd_en   = 1'b1;
      bus.rd_addr = ADDR_W'(a);
      exp_q.push_back(e);
      step();
      bus.rd_en = 1'b0;
      check("fetch_latency", 64'(bus.instr_valid), 64'd1);
   endtask

   task automatic model_accept(inout int ptr, inout int cnt, input logic [IW-1:0] d);
      if (ptr < DEPTH) model_mem[ptr] = d;
      else m_err = 1'b1;
      m_csum = m_csum ^ d;
      ptr = (ptr + 1) % 256;
      cnt = cnt - 1;
   endtask

   // mode 0: ld_valid held high, 1: toggling 1,0,1.., 2: random
   task automatic load(input int base, input int len, input int mode, input bit fetch_in_load);
      int ptr, cnt, idx, guard;
      logic v;
      bus.ld_start = 1'b1;
      bus.ld_base  = ADDR_W'(base);
      bus.ld_len   = (ADDR_W+1)'(len);
      if (fetch_in_load) begin
         bus.rd_en   = 1'b1;
         bus.rd_addr = ADDR_W'(7);
         exp_q.push_back(model_exp(7));
      end
      step();
      bus.ld_start = 1'b0;
      bus.rd_en    = 1'b0;
      if (fetch_in_load) check("start_cycle_fetch", 64'(bus.instr_valid), 64'd1);
      ptr = base; cnt = len; idx = 0; guard = 0;
      m_csum = '0; m_err = 1'b0;
      if (len == 0) check("zero_len_busy", 64'(bus.ld_busy), 64'd0);
      else check("load_state", 64'(fsm_state), 64'd1);
      while (cnt > 0 && guard < 1000) begin
         if (mode == 0) v = 1'b1;
         else if (mode == 1) v = (guard % 2 == 0);
         else v = 1'($urandom_range(0, 1));
         bus.ld_valid = v;
         bus.ld_data  = (idx < ld_words.size()) ? ld_words[idx] : '0;
         if (fetch_in_load) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = ADDR_W'($urandom_range(0, 255));
         end
         check("ld_ready", 64'(bus.ld_ready), 64'd1);
         check("ld_busy", 64'(bus.ld_busy), 64'd1);
         if (v) begin
            model_accept(ptr, cnt, bus.ld_data);
            idx++;
         end
         step();
         guard++;
         check("ld_err_run", 64'(bus.ld_err), 64'(m_err));
         if (fetch_in_load) check("fetch_blocked", 64'(bus.instr_valid), 64'd0);
      end
      bus.ld_valid = 1'b0;
      bus.rd_en    = 1'b0;
      check("ld_done", 64'(bus.ld_done), 64'd1);
      check("done_ready", 64'(bus.ld_ready), 64'd0);
      check("done_busy", 64'(bus.ld_busy), 64'd0);
      check("ld_csum", 64'(bus.ld_csum), 64'(m_csum));
      check("ld_err", 64'(bus.ld_err), 64'(m_err));
      check("done_state", 64'(fsm_state), 64'd2);
      step();
      check("done_pulse_end", 64'(bus.ld_done), 64'd0);
      check("idle_state", 64'(fsm_state), 64'd0);
      check("csum_hold", 64'(bus.ld_csum), 64'(m_csum));
   endtask

   task automatic rand_words(input int n);
      ld_words.delete();
      for (int i = 0; i < n; i++) ld_words.push_back(IW'($urandom()));
   endtask

   initial begin
      int p, c;
      reset        = 1'b1;
      bus.rd_en    = 1'b0;
      bus.rd_addr  = '0;
      bus.ld_start = 1'b0;
      bus.ld_base  = '0;
      bus.ld_len   = '0;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      repeat (3) step();

      check("rst_instr_out", 64'(bus.instr_out), 64'd0);
      check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
      check("rst_addr_err", 64'(bus.addr_err), 64'd0);
      check("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
      check("rst_ld_busy", 64'(bus.ld_busy), 64'd0);
      check("rst_ld_done", 64'(bus.ld_done), 64'd0);
      check("rst_ld_err", 64'(bus.ld_err), 64'd0);
      check("rst_ld_csum", 64'(bus.ld_csum), 64'd0);
      check("rst_state", 64'(fsm_state), 64'd0);
      reset = 1'b0;
      step();

      // fill the whole memory with a known pattern
      ld_words.delete();
      for (int i = 0; i < DEPTH; i++) ld_words.push_back(pat(i));
      load(0, DEPTH, 0, 1'b0);

      // table-driven fetches against the fill pattern
      vecs[0] = '{8'd5,   1'b0, pat(5)};
      vecs[1] = '{8'd100, 1'b0, pat(100)};
      vecs[2] = '{8'd200, 1'b0, pat(200)};
      vecs[3] = '{8'd201, 1'b1, NOP_WORD};
      vecs[4] = '{8'd210, 1'b1, NOP_WORD};
      vecs[5] = '{8'd255, 1'b1, NOP_WORD};
      vecs[6] = '{8'd0,   1'b0, pat(0)};
      vecs[7] = '{8'd37,  1'b0, pat(37)};
      for (int i = 0; i < 8; i++) fetch(int'(vecs[i].addr), {vecs[i].exp_err, vecs[i].exp_word});
      step();
      check("rd_idle_valid", 64'(bus.instr_valid), 64'd0);
      check("rd_idle_hold", 64'(bus.instr_out), 64'(pat(37)));

      // three-word program at address 0
      ld_words.delete();
      ld_words.push_back({8'd2, 18'd0});
      ld_words.push_back({8'd4, 18'd20});
      ld_words.push_back({8'd47, 18'd8});
      load(0, 3, 0, 1'b0);
      check("t1_csum_const", 64'(bus.ld_csum), 64'({8'd2, 18'd0} ^ {8'd4, 18'd20} ^ {8'd47, 18'd8}));
      fetch(1, model_exp(1));
      check("t1_opcode", 64'(bus.opcode_out), 64'd4);
      check("t1_operand", 64'(bus.operand_out), 64'd20);

      // out-of-range fetch then in-range
      fetch(210, model_exp(210));
      check("t2_nop_word", 64'(bus.instr_out), 64'(NOP_WORD));
      check("t2_addr_err", 64'(bus.addr_err), 64'd1);
      fetch(0, model_exp(0));
      check("t2_addr_err_clr", 64'(bus.addr_err), 64'd0);

      // toggling ld_valid
      rand_words(3);
      load(50, 3, 1, 1'b0);
      for (int a = 50; a < 54; a++) fetch(a, model_exp(a));

      // load running past the end of memory
      rand_words(4);
      load(199, 4, 0, 1'b0);
      check("t4_err_const", 64'(bus.ld_err), 64'd1);
      fetch(199, model_exp(199));
      fetch(200, model_exp(200));
      fetch(0, {1'b0, 8'd2, 18'd0});
      fetch(1, {1'b0, 8'd4, 18'd20});

      // reset after two of five words
      rand_words(5);
      bus.ld_start = 1'b1;
      bus.ld_base  = ADDR_W'(20);
      bus.ld_len   = (ADDR_W+1)'(5);
      step();
      bus.ld_start = 1'b0;
      p = 20; c = 5; m_csum = '0; m_err = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = ld_words[i];
         model_accept(p, c, ld_words[i]);
         step();
      end
      bus.ld_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_state", 64'(fsm_state), 64'd0);
      check("t5_busy", 64'(bus.ld_busy), 64'd0);
      check("t5_done", 64'(bus.ld_done), 64'd0);
      check("t5_csum", 64'(bus.ld_csum), 64'd0);
      check("t5_err", 64'(bus.ld_err), 64'd0);
      step();
      check("t5_no_done", 64'(bus.ld_done), 64'd0);
      fetch(20, model_exp(20));
      fetch(21, model_exp(21));
      fetch(22, {1'b0, pat(22)});

      // reset and ld_start in the same cycle
      reset        = 1'b1;
      bus.ld_start = 1'b1;
      bus.ld_base  = ADDR_W'(90);
      bus.ld_len   = (ADDR_W+1)'(3);
      step();
      reset        = 1'b0;
      bus.ld_start = 1'b0;
      check("rst_start_state", 64'(fsm_state), 64'd0);
      step();
      check("rst_start_busy", 64'(bus.ld_busy), 64'd0);

      // zero-length load, then a random load with fetches attempted throughout
      load(30, 0, 0, 1'b0);
      rand_words(4);
      load(60, 4, 2, 1'b1);
      for (int a = 60; a < 64; a++) fetch(a, model_exp(a));

      repeat (3) step();
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
Parametrised synchronous instruction memory for the convolution processor. It adds a streaming program-load port with a valid/ready handshake, a load FSM, bounds checking and a load checksum. The controller fetches through a registered read port; the opcode/operand split is exposed directly. It sits between the control unit (fetch side) and the host/testbench program loader.

Parameters:
OPCODE_W, 8, opcode field width
OPERAND_W, 18, operand/immediate field width
ADDR_W, 8, address width
DEPTH, 201, number of implemented words (DEPTH <= 2**ADDR_W)
NOP_OPCODE, 46, opcode returned for out-of-range fetches
(derived) IW = OPCODE_W+OPERAND_W

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
rd_en  in  1  fetch request
rd_addr  in  ADDR_W  fetch address
instr_out  out  IW  fetched word {opcode, operand}
opcode_out  out  OPCODE_W  instr_out[IW-1 -: OPCODE_W]
operand_out  out  OPERAND_W  instr_out[OPERAND_W-1:0]
instr_valid  out  1  instr_out holds a fresh fetch result
addr_err  out  1  fetch of the current instr_out was out of range
ld_start  in  1  begin load (pulse)
ld_base  in  ADDR_W  first write address
ld_len  in  ADDR_W+1  number of words to load
ld_valid  in  1  ld_data valid
ld_data  in  IW  program word
ld_ready  out  1  loader accepts ld_data
ld_busy  out  1  load in progress; fetch blocked
ld_done  out  1  one-cycle pulse at load completion
ld_err  out  1  sticky: a load word targeted address >= DEPTH
ld_csum  out  IW  XOR of all accepted load words

Behaviour:
- Reset: instr_out=0, instr_valid=0, addr_err=0, ld_ready=0, ld_busy=0, ld_done=0, ld_err=0, ld_csum=0, FSM=IDLE. Memory contents are not cleared by reset.
- Fetch path (FSM in IDLE or DONE), when rd_en=1:
  - rd_addr < DEPTH: instr_out <= mem[rd_addr] next cycle; instr_valid=1; addr_err=0.
  - rd_addr >= DEPTH: instr_out <= {NOP_OPCODE, 0}; instr_valid=1; addr_err=1.
- Fetch path, other cases:
  - rd_en=0: instr_out holds its value; instr_valid=0.
  - Latency is exactly 1 cycle.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - ld_start=1: latch ptr=ld_base and cnt=ld_len; clear ld_csum and ld_err.
  - If ld_len=0, go to DONE; otherwise go to LOAD.
  - A fetch issued in the same cycle as ld_start is still served.
- LOAD:
  - ld_ready=1 and ld_busy=1. rd_en is ignored; instr_valid=0.
  - On ld_valid&ld_ready:
    - If ptr < DEPTH, write mem[ptr]=ld_data; otherwise discard the word and set ld_err=1.
    - ld_csum ^= ld_data.
    - ptr = ptr+1 mod 2**ADDR_W; cnt = cnt-1.
  - When the last word is accepted (cnt==1), go to DONE.
  - ld_start is ignored while in LOAD.
- DONE: ld_done=1 for this single cycle, ld_ready=0, ld_busy=0; go to IDLE next cycle. Fetch is allowed in DONE.
- Read-after-load: a word written in cycle N is readable by a fetch issued in cycle N+1 or later.
- Reset mid-load: FSM returns to IDLE. Already-written words are kept. ld_csum and ld_err are cleared; no ld_done is produced.
- Simultaneous ld_start and reset: reset wins.
- ld_err and ld_csum hold their values until the next accepted ld_start or reset.

Test Plan:
1. Load 3 words {8'd2,18'd0},{8'd4,18'd20},{8'd47,18'd8} at ld_base=0 with ld_valid held high -> ld_ready high for 3 cycles; ld_done pulses in the cycle after the 3rd accept; ld_csum = XOR of the 3 words. A subsequent fetch of addr 1 gives opcode_out=4 and operand_out=20, one cycle after rd_en.
2. Fetch rd_addr=210 with DEPTH=201 -> next cycle instr_out={46,0}, addr_err=1, instr_valid=1. Then fetch addr 0 -> addr_err=0.
3. Load with ld_valid toggling 1,0,1,0,1 for ld_len=3 -> exactly 3 writes, cnt decrements only on accepted words, ld_done 1 cycle after the last accept.
4. ld_base=199, ld_len=4 with DEPTH=201 -> addresses 199 and 200 written; the next two words are discarded; ld_err=1 after the third accept; mem[0] and mem[1] are unchanged.
5. Assert reset after 2 of 5 words -> FSM in IDLE, ld_busy=0, no ld_done; fetch of ld_base and ld_base+1 returns the loaded words; ld_base+2 keeps its old content.
6. ld_len=0 -> ld_busy never asserts; ld_done pulses the cycle after ld_start; rd_en during LOAD of another load -> instr_valid stays 0.
